// File: rtl/barrier_ram_if.sv
// Request/response bundle between the display fetcher, the game engine,
// the barrier RAM arbiter and the barrier/playfield SRAM pins.
interface barrier_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_ack;
  logic [DATA_WIDTH-1:0] vga_data;
  logic                  vga_valid;

  logic                  game_req;
  logic                  game_we;
  logic [ADDR_WIDTH-1:0] game_addr;
  logic [DATA_WIDTH-1:0] game_wdata;
  logic                  game_ack;
  logic [DATA_WIDTH-1:0] game_rdata;
  logic                  game_rvalid;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Requesters plus the SRAM instance
  modport master (
    output vga_req, vga_addr, game_req, game_we, game_addr, game_wdata, ram_rdata,
    input  vga_ack, vga_data, vga_valid, game_ack, game_rdata, game_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  // Arbiter side
  modport slave (
    input  vga_req, vga_addr, game_req, game_we, game_addr, game_wdata, ram_rdata,
    output vga_ack, vga_data, vga_valid, game_ack, game_rdata, game_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/barrier_ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port barrier SRAM.
// Optional level-start clear sweep is built when BARRIER_CLEAR_EN is defined.
module barrier_ram_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int RAM_SIZE     = 65536,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
`ifdef BARRIER_CLEAR_EN
  input  logic clear_start,
  output logic clear_busy,
`endif
  barrier_ram_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  if (RAM_SIZE < 1 || RAM_SIZE > (1 << ADDR_WIDTH)) begin : g_bad_ram_size
    $error("barrier_ram_arbiter: RAM_SIZE does not fit ADDR_WIDTH");
  end

`ifdef BARRIER_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);
  typedef enum logic [0:0] {ARB = 1'b0, CLEAR = 1'b1} state_t;
  logic clear_busy_r;
`else
  typedef enum logic [0:0] {ARB = 1'b0} state_t;
`endif

  state_t                state_r;
  logic [SW-1:0]         starve_cnt_r;
  logic                  ram_en_r;
  logic                  ram_we_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic                  rd1_vld_r;
  logic                  rd1_game_r;
  logic                  vga_valid_r;
  logic                  game_rvalid_r;

  logic                  arb_ok_s;
  logic                  force_game_s;
  logic                  grant_vga_s;
  logic                  grant_game_s;

  // Grant decode: VGA first unless the game has waited STARVE_LIMIT cycles
  always_comb begin
    arb_ok_s = 1'b1;
`ifdef BARRIER_CLEAR_EN
    if (state_r != ARB || clear_start) begin
      arb_ok_s = 1'b0;
    end else begin
      arb_ok_s = 1'b1;
    end
`endif
    force_game_s = bus.game_req && (starve_cnt_r == SW'(STARVE_LIMIT));
    grant_game_s = arb_ok_s && bus.game_req && (force_game_s || !bus.vga_req);
    grant_vga_s  = arb_ok_s && bus.vga_req && !force_game_s;
  end

  // Arbitration state, SRAM command registers and read-valid pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ARB;
      starve_cnt_r  <= SW'(0);
      ram_en_r      <= 1'b0;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= ADDR_WIDTH'(0);
      ram_wdata_r   <= DATA_WIDTH'(0);
      rd1_vld_r     <= 1'b0;
      rd1_game_r    <= 1'b0;
      vga_valid_r   <= 1'b0;
      game_rvalid_r <= 1'b0;
`ifdef BARRIER_CLEAR_EN
      clear_busy_r  <= 1'b0;
`endif
    end else begin
      if (!bus.game_req || grant_game_s) begin
        starve_cnt_r <= SW'(0);
      end else if (starve_cnt_r != SW'(STARVE_LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      // Owner travels with the read so returning data is steered correctly
      rd1_vld_r     <= grant_vga_s || (grant_game_s && !bus.game_we);
      rd1_game_r    <= grant_game_s;
      vga_valid_r   <= rd1_vld_r && !rd1_game_r;
      game_rvalid_r <= rd1_vld_r && rd1_game_r;

      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
`ifdef BARRIER_CLEAR_EN
      clear_busy_r <= 1'b0;
`endif
      case (state_r)
        ARB: begin
`ifdef BARRIER_CLEAR_EN
          if (clear_start) begin
            // First sweep write is issued on the entry edge
            state_r      <= CLEAR;
            clear_busy_r <= 1'b1;
            ram_en_r     <= 1'b1;
            ram_we_r     <= 1'b1;
            ram_addr_r   <= ADDR_WIDTH'(0);
            ram_wdata_r  <= DATA_WIDTH'(0);
          end else
`endif
          if (grant_game_s) begin
            ram_en_r    <= 1'b1;
            ram_we_r    <= bus.game_we;
            ram_addr_r  <= bus.game_addr;
            ram_wdata_r <= bus.game_wdata;
          end else if (grant_vga_s) begin
            ram_en_r   <= 1'b1;
            ram_addr_r <= bus.vga_addr;
          end else begin
            ram_addr_r <= ram_addr_r;
          end
        end
`ifdef BARRIER_CLEAR_EN
        CLEAR: begin
          // ram_addr_r doubles as the sweep counter; stop once the last word is out
          if (ram_addr_r == LAST_ADDR) begin
            state_r <= ARB;
          end else begin
            clear_busy_r <= 1'b1;
            ram_en_r     <= 1'b1;
            ram_we_r     <= 1'b1;
            ram_addr_r   <= ram_addr_r + ADDR_WIDTH'(1);
            ram_wdata_r  <= DATA_WIDTH'(0);
          end
        end
`endif
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  assign bus.vga_ack     = grant_vga_s;
  assign bus.game_ack    = grant_game_s;
  assign bus.vga_data    = bus.ram_rdata;
  assign bus.game_rdata  = bus.ram_rdata;
  assign bus.vga_valid   = vga_valid_r;
  assign bus.game_rvalid = game_rvalid_r;
  assign bus.ram_en      = ram_en_r;
  assign bus.ram_we      = ram_we_r;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_wdata   = ram_wdata_r;
`ifdef BARRIER_CLEAR_EN
  assign clear_busy      = clear_busy_r;
`endif

endmodule

// File: tb/tb_barrier_ram_arbiter.sv
// Directed bench for barrier_ram_arbiter with a registered-read, write-through SRAM model.
module tb_barrier_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int RS = 16;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic reset;
`ifdef BARRIER_CLEAR_EN
  logic clear_start;
  logic clear_busy;
`endif
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  barrier_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  barrier_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RS), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef BARRIER_CLEAR_EN
    .clear_start(clear_start),
    .clear_busy(clear_busy),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle registered read, write-through on writes
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata     <= bus.ram_wdata;
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef BARRIER_CLEAR_EN
    clear_start = 1'b0;
`endif
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ram_en",    32'(bus.ram_en), 32'd0);
    chk("rst_ram_we",    32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
    chk("rst_game_rv",   32'(bus.game_rvalid), 32'd0);
    chk("rst_acks",      32'({bus.vga_ack, bus.game_ack}), 32'd0);
`ifdef BARRIER_CLEAR_EN
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
`endif

    preload(16'h0010, 8'hA5);
    for (int i = 0; i < RS; i++) preload(16'(i), 8'(8'h50 + i));

    // Single VGA read
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0010; #1;
    chk("v1_ack", 32'(bus.vga_ack), 32'd1);
    chk("v1_gack", 32'(bus.game_ack), 32'd0);
    tick(); bus.vga_req = 1'b0; #1;
    chk("v1_ram_en", 32'(bus.ram_en), 32'd1);
    chk("v1_ram_we", 32'(bus.ram_we), 32'd0);
    chk("v1_ram_addr", 32'(bus.ram_addr), 32'h0010);
    chk("v1_valid_n1", 32'(bus.vga_valid), 32'd0);
    tick();
    chk("v1_valid", 32'(bus.vga_valid), 32'd1);
    chk("v1_data", 32'(bus.vga_data), 32'hA5);
    chk("v1_game_rv", 32'(bus.game_rvalid), 32'd0);
    tick();
    chk("v1_valid_drop", 32'(bus.vga_valid), 32'd0);

    // Game write then read of 0x1234
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 16'h1234; bus.game_wdata = 8'h3C; #1;
    chk("gw_ack", 32'(bus.game_ack), 32'd1);
    tick(); bus.game_req = 1'b0; #1;
    chk("gw_ram_en", 32'(bus.ram_en), 32'd1);
    chk("gw_ram_we", 32'(bus.ram_we), 32'd1);
    chk("gw_ram_addr", 32'(bus.ram_addr), 32'h1234);
    chk("gw_ram_wdata", 32'(bus.ram_wdata), 32'h3C);
    tick();
    chk("gw_no_rvalid", 32'(bus.game_rvalid), 32'd0);
    bus.game_req = 1'b1; bus.game_we = 1'b0; #1;
    chk("gr_ack", 32'(bus.game_ack), 32'd1);
    tick(); bus.game_req = 1'b0; #1;
    chk("gr_ram_we", 32'(bus.ram_we), 32'd0);
    tick();
    chk("gr_rvalid", 32'(bus.game_rvalid), 32'd1);
    chk("gr_rdata", 32'(bus.game_rdata), 32'h3C);
    chk("gr_vga_valid", 32'(bus.vga_valid), 32'd0);
    tick();

    // Contention: VGA wins 8 times, then the game is forced through
    bus.vga_addr = 16'h0010; bus.game_addr = 16'h1234; bus.game_we = 1'b0;
    bus.vga_req = 1'b1; bus.game_req = 1'b1;
    for (int i = 1; i <= SL; i++) begin
      #1;
      chk("ct_vga_ack", 32'(bus.vga_ack), 32'd1);
      chk("ct_game_ack", 32'(bus.game_ack), 32'd0);
      tick();
    end
    #1;
    chk("ct_force_gack", 32'(bus.game_ack), 32'd1);
    chk("ct_force_vack", 32'(bus.vga_ack), 32'd0);
    tick(); bus.game_req = 1'b0; #1;
    chk("ct_vga_resume", 32'(bus.vga_ack), 32'd1);
    tick(); bus.vga_req = 1'b0; #1;
    chk("ct_game_rv", 32'(bus.game_rvalid), 32'd1);
    chk("ct_game_rdata", 32'(bus.game_rdata), 32'h3C);
    chk("ct_vga_v0", 32'(bus.vga_valid), 32'd0);
    tick();
    chk("ct_vga_v1", 32'(bus.vga_valid), 32'd1);
    chk("ct_vga_data", 32'(bus.vga_data), 32'hA5);
    chk("ct_game_rv0", 32'(bus.game_rvalid), 32'd0);
    tick();

    // Idle hold
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_en", 32'(bus.ram_en), 32'd0);
      chk("idle_we", 32'(bus.ram_we), 32'd0);
      chk("idle_addr", 32'(bus.ram_addr), 32'h0010);
      tick();
    end

`ifdef BARRIER_CLEAR_EN
    // Clear sweep with both requesters pending
    bus.vga_req = 1'b1; bus.game_req = 1'b1; clear_start = 1'b1; #1;
    chk("cl_entry_vack", 32'(bus.vga_ack), 32'd0);
    chk("cl_entry_gack", 32'(bus.game_ack), 32'd0);
    tick(); clear_start = 1'b0;
    for (int k = 0; k < RS; k++) begin
      #1;
      chk("cl_busy", 32'(clear_busy), 32'd1);
      chk("cl_en_we", 32'({bus.ram_en, bus.ram_we}), 32'd3);
      chk("cl_wdata", 32'(bus.ram_wdata), 32'd0);
      chk("cl_addr", 32'(bus.ram_addr), 32'(k));
      chk("cl_acks", 32'({bus.vga_ack, bus.game_ack}), 32'd0);
      tick();
    end
    #1;
    chk("cl_done_busy", 32'(clear_busy), 32'd0);
    chk("cl_starved_gack", 32'(bus.game_ack), 32'd1);
    chk("cl_starved_vack", 32'(bus.vga_ack), 32'd0);
    tick(); bus.game_req = 1'b0;
    for (int i = 0; i < RS + 2; i++) begin
      bus.vga_req = (i < RS); bus.vga_addr = 16'(i); #1;
      if (i == 1) begin
        chk("cl_game_rv", 32'(bus.game_rvalid), 32'd1);
        chk("cl_game_rdata", 32'(bus.game_rdata), 32'h3C);
      end
      if (i >= 2) begin
        chk("rb_valid", 32'(bus.vga_valid), 32'd1);
        chk("rb_zero", 32'(bus.vga_data), 32'd0);
      end
      tick();
    end
    bus.vga_req = 1'b0;
    tick(); tick();
`endif

    // Reset in the cycle after a read grant
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0010; #1;
    chk("rr_ack", 32'(bus.vga_ack), 32'd1);
    tick(); bus.vga_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; #1;
    chk("rr_valid", 32'(bus.vga_valid), 32'd0);
    chk("rr_en_we", 32'({bus.ram_en, bus.ram_we}), 32'd0);
    chk("rr_addr", 32'(bus.ram_addr), 32'd0);
    chk("rr_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rr_game_rv", 32'(bus.game_rvalid), 32'd0);
    tick();
    chk("rr_valid_late", 32'(bus.vga_valid), 32'd0);

`ifdef BARRIER_CLEAR_EN
    // Reset midway through a sweep
    clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rc_busy_mid", 32'(clear_busy), 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    chk("rc_busy", 32'(clear_busy), 32'd0);
    chk("rc_en_we", 32'({bus.ram_en, bus.ram_we}), 32'd0);
    chk("rc_addr", 32'(bus.ram_addr), 32'd0);
    tick();
    chk("rc_busy_late", 32'(clear_busy), 32'd0);
    chk("rc_en_late", 32'(bus.ram_en), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
